video_fb_arbiter: RTL and testbench

Sequences a single-port 1 bpp framebuffer RAM for the raw composite video generator. It shares the RAM between two requesters: raster pixel prefetch, which has absolute priority, and a host write port using a req/ack handshake. It takes the generator's pixel enable and x/y coordinates, fetches 16-pixel words ahead of the beam, and returns the pixel bit for the current coordinate in the same cycle.

---
 rtl/video_fb_arbiter.sv | 277 +++++++++++++++++++++++++++
 tb/tb_video_fb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fb_arbiter.sv
// ============================================================================
// video_fb_arbiter
//
// Sequences a single-port 1 bpp framebuffer RAM for the composite video
// generator. Raster prefetch owns the RAM whenever it needs it; a host port
// (req/ack handshake) gets every slot the raster leaves free.
//
// The displayed 16-pixel word lives in cur_word, the following word in
// next_word. Inside a line, the word after next is fetched at a fixed x
// phase (PREFETCH_SLOT). During horizontal blanking a short burst loads
// words 0 and 1 of the next line.
//
// Ports:
//   clk, rst        12 MHz clock, asynchronous active-low reset
//   i_enable        raster pixel enable
//   i_pixel_x/y     raster coordinates (x 0..498, y 0..LAST_LINE)
//   o_pixel         pixel bit for the current coordinate (combinational)
//   o_mem_addr      RAM word address {y, word}           (registered)
//   o_mem_rd        RAM read strobe, data one cycle later (registered)
//   o_mem_we        RAM write strobe                     (registered)
//   o_mem_wdata     RAM write data                       (registered)
//   i_mem_rdata     RAM read data
//   i_host_req      host request, held until acknowledged
//   i_host_addr     host word address
//   i_host_data     host write data
//   o_host_ack      one-cycle acknowledge pulse
//
// Optional feature (macro VIDEO_FB_HOST_READ_EN):
//   i_host_wr       1 = write, 0 = read
//   o_host_rdata    host read data, valid while o_host_ack is high
//   A host read issues o_mem_rd and acknowledges in the data cycle; no video
//   read may start in that data cycle, so a colliding in-line fetch is held
//   for one cycle.
// ============================================================================
module video_fb_arbiter #(
    parameter int unsigned PREFETCH_SLOT = 4,
    parameter int unsigned LAST_LINE     = 229
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [8:0]  i_pixel_x,
    input  logic [7:0]  i_pixel_y,
    output logic        o_pixel,
    output logic [12:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_we,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_host_req,
    input  logic [12:0] i_host_addr,
    input  logic [15:0] i_host_data,
`ifdef VIDEO_FB_HOST_READ_EN
    input  logic        i_host_wr,
    output logic [15:0] o_host_rdata,
`endif
    output logic        o_host_ack
);

    localparam logic [3:0] SLOT   = 4'(PREFETCH_SLOT);
    localparam logic [7:0] LAST_Y = 8'(LAST_LINE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_D1
    } state_t;

    // Destination of a read: travels with o_mem_rd, then with the data cycle.
    typedef enum logic [1:0] {
        T_NONE,
        T_CUR,
        T_NEXT,
        T_HOST
    } tag_t;

    state_t      state_q,      state_d;
    logic [7:0]  fetch_line_q, fetch_line_d;
    logic [15:0] cur_word_q,   cur_word_d;
    logic [15:0] next_word_q,  next_word_d;
    logic [12:0] mem_addr_q,   mem_addr_d;
    logic        mem_rd_q,     mem_rd_d;
    logic        mem_we_q,     mem_we_d;
    logic [15:0] mem_wdata_q,  mem_wdata_d;
    logic        host_ack_q,   host_ack_d;
    tag_t        rd_tag_q,     rd_tag_d;
    tag_t        cap_tag_q,    cap_tag_d;
    logic        pend_q,       pend_d;
    logic [12:0] pend_addr_q,  pend_addr_d;
    logic        en_q;

    logic [4:0]  word_idx;
    logic [3:0]  bit_sel;
    logic        fall_edge;
    logic        inline_go;
    logic [12:0] inline_addr;
    logic        host_rd_busy;
    logic        host_wr_sel;
    logic        vid_go;
    logic [12:0] vid_addr;
    tag_t        vid_tag;
    logic        host_go;

    assign word_idx    = i_pixel_x[8:4];
    // Bit 15 is the leftmost pixel, so the bit index is 15 - x[3:0].
    assign bit_sel     = ~i_pixel_x[3:0];
    assign o_pixel     = i_enable & cur_word_q[bit_sel];
    assign fall_edge   = en_q & ~i_enable;

    // Word 0 and word 1 come from the blanking burst and word 31 has no
    // successor, so only words 1..30 trigger a fetch of the following word.
    assign inline_go   = i_enable && (i_pixel_x[3:0] == SLOT) &&
                         (word_idx >= 5'd1) && (word_idx <= 5'd30);
    assign inline_addr = {i_pixel_y, word_idx + 5'd1};

    // A host read was put on the bus this cycle: next cycle is its data
    // cycle, which no new command may use.
    assign host_rd_busy = (rd_tag_q == T_HOST);

`ifdef VIDEO_FB_HOST_READ_EN
    assign host_wr_sel  = i_host_wr;
    assign o_host_rdata = i_mem_rdata;
`else
    assign host_wr_sel  = 1'b1;
`endif

    assign o_mem_addr  = mem_addr_q;
    assign o_mem_rd    = mem_rd_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_host_ack  = host_ack_q;

    always_comb begin
        state_d      = state_q;
        fetch_line_d = fetch_line_q;
        cur_word_d   = cur_word_q;
        next_word_d  = next_word_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = 1'b0;
        mem_we_d     = 1'b0;
        host_ack_d   = 1'b0;
        rd_tag_d     = T_NONE;
        cap_tag_d    = rd_tag_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        vid_go       = 1'b0;
        vid_addr     = '0;
        vid_tag      = T_NONE;
        host_go      = 1'b0;

        // Blanking burst: word 0 -> cur_word, word 1 -> next_word.
        case (state_q)
            S_IDLE: begin
                if (fall_edge) begin
                    fetch_line_d = (i_pixel_y == LAST_Y) ? 8'd0 : i_pixel_y + 8'd1;
                    state_d      = S_F0;
                end
            end
            S_F0: begin
                if (!host_rd_busy) begin
                    vid_go   = 1'b1;
                    vid_addr = {fetch_line_q, 5'd0};
                    vid_tag  = T_CUR;
                    state_d  = S_F1;
                end
            end
            S_F1: begin
                if (!host_rd_busy) begin
                    vid_go   = 1'b1;
                    vid_addr = {fetch_line_q, 5'd1};
                    vid_tag  = T_NEXT;
                    state_d  = S_D1;
                end
            end
            S_D1: begin
                // Word 1 lands this cycle; the burst is then complete.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // In-line prefetch. If it collides with a host read data cycle it is
        // parked for one cycle; the swap at x[3:0]=15 still has ample margin.
        if (host_rd_busy) begin
            if (inline_go) begin
                pend_d      = 1'b1;
                pend_addr_d = inline_addr;
            end
        end else if (!vid_go) begin
            if (pend_q) begin
                vid_go   = 1'b1;
                vid_addr = pend_addr_q;
                vid_tag  = T_NEXT;
                pend_d   = 1'b0;
            end else if (inline_go) begin
                vid_go   = 1'b1;
                vid_addr = inline_addr;
                vid_tag  = T_NEXT;
            end
        end

        // Host only takes a slot no video read wants. A request still high
        // in its own ack cycle is the same access and must not repeat.
        host_go = i_host_req && !vid_go && !host_ack_q && !host_rd_busy && !pend_q;

        if (vid_go) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = vid_addr;
            rd_tag_d   = vid_tag;
        end else if (host_go) begin
            mem_addr_d = i_host_addr;
            if (host_wr_sel) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = i_host_data;
                host_ack_d  = 1'b1;
            end else begin
                mem_rd_d = 1'b1;
                rd_tag_d = T_HOST;
            end
        end

        // Host read acknowledges in its data cycle, alongside the RAM data.
        if (rd_tag_q == T_HOST) begin
            host_ack_d = 1'b1;
        end

        // Swap at the last pixel of a word; a landing read takes precedence.
        if (i_enable && (i_pixel_x[3:0] == 4'hF)) begin
            cur_word_d = next_word_q;
        end
        case (cap_tag_q)
            T_CUR:   cur_word_d  = i_mem_rdata;
            T_NEXT:  next_word_d = i_mem_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Starting in S_F0 prefetches line 0 right after reset.
            state_q      <= S_F0;
            fetch_line_q <= 8'd0;
            cur_word_q   <= 16'd0;
            next_word_q  <= 16'd0;
            mem_addr_q   <= 13'd0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 16'd0;
            host_ack_q   <= 1'b0;
            rd_tag_q     <= T_NONE;
            cap_tag_q    <= T_NONE;
            pend_q       <= 1'b0;
            pend_addr_q  <= 13'd0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_line_q <= fetch_line_d;
            cur_word_q   <= cur_word_d;
            next_word_q  <= next_word_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            host_ack_q   <= host_ack_d;
            rd_tag_q     <= rd_tag_d;
            cap_tag_q    <= cap_tag_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            en_q         <= i_enable;
        end
    end

endmodule

// File: tb/tb_video_fb_arbiter.sv
module tb_video_fb_arbiter;

    localparam int PSLOT = 4;
    localparam int LAST  = 229;

    logic        clk;
    logic        rst;
    logic        i_enable;
    logic [8:0]  i_pixel_x;
    logic [7:0]  i_pixel_y;
    logic        o_pixel;
    logic [12:0] o_mem_addr;
    logic        o_mem_rd;
    logic        o_mem_we;
    logic [15:0] o_mem_wdata;
    logic [15:0] mem_rdata;
    logic        host_req;
    logic [12:0] host_addr;
    logic [15:0] host_data;
    logic        o_host_ack;
`ifdef VIDEO_FB_HOST_READ_EN
    logic        host_wr;
    logic [15:0] o_host_rdata;
`endif

    logic [15:0] mem [0:8191];
    logic [7:0]  disp;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        string       nm;
        int          cyc;
        bit          rd;
        bit          we;
        bit          ack;
        logic [12:0] addr;
        logic [15:0] dat;
    } ev_t;

    ev_t exp_q[$];
    bit  pix_q[$];

    video_fb_arbiter #(.PREFETCH_SLOT(PSLOT), .LAST_LINE(LAST)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_pixel_x    (i_pixel_x),
        .i_pixel_y    (i_pixel_y),
        .o_pixel      (o_pixel),
        .o_mem_addr   (o_mem_addr),
        .o_mem_rd     (o_mem_rd),
        .o_mem_we     (o_mem_we),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .i_host_req   (host_req),
        .i_host_addr  (host_addr),
        .i_host_data  (host_data),
`ifdef VIDEO_FB_HOST_READ_EN
        .i_host_wr    (host_wr),
        .o_host_rdata (o_host_rdata),
`endif
        .o_host_ack   (o_host_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int i);
        if (i == 0)     return 16'h8001;
        if (i == 'h123) return 16'hBEEF;
        return 16'((i * 40503) ^ (i >>> 2) ^ 16'h3C5A);
    endfunction

    // RAM model: contents reloaded during reset, 1-cycle read latency.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_val(i);
        end else if (o_mem_we) begin
            mem[o_mem_addr] <= o_mem_wdata;
        end
        if (o_mem_rd) mem_rdata <= mem[o_mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic exp_rd(input string nm, input int c, input logic [12:0] a);
        ev_t e;
        e.nm = nm; e.cyc = c; e.rd = 1'b1; e.we = 1'b0; e.ack = 1'b0; e.addr = a; e.dat = 16'h0;
        exp_q.push_back(e);
    endtask

    task automatic exp_wr(input string nm, input int c, input logic [12:0] a, input logic [15:0] d);
        ev_t e;
        e.nm = nm; e.cyc = c; e.rd = 1'b0; e.we = 1'b1; e.ack = 1'b1; e.addr = a; e.dat = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_ack(input string nm, input int c, input logic [15:0] d);
        ev_t e;
        e.nm = nm; e.cyc = c; e.rd = 1'b0; e.we = 1'b0; e.ack = 1'b1; e.addr = 13'h0; e.dat = d;
        exp_q.push_back(e);
    endtask

    // Monitor: checks every RAM/host event and every pixel against the queues.
    initial begin
        ev_t         e;
        bit          ok;
        bit          p;
        logic [15:0] ard;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && (o_mem_rd || o_mem_we || o_host_ack)) begin
                ard = 16'h0;
`ifdef VIDEO_FB_HOST_READ_EN
                ard = o_host_rdata;
`endif
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL ev_unexpected: got cyc=%0d rd=%b we=%b ack=%b addr=%h wd=%h, required no access",
                             cyc, o_mem_rd, o_mem_we, o_host_ack, o_mem_addr, o_mem_wdata);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (e.cyc == cyc) && (e.rd == o_mem_rd) && (e.we == o_mem_we) && (e.ack == o_host_ack);
                    if (ok && (e.rd || e.we)) ok = (e.addr == o_mem_addr);
                    if (ok && e.we) ok = (e.dat == o_mem_wdata);
                    if (ok && e.ack && !e.we) ok = (e.dat == ard);
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL ev_%s: got cyc=%0d rd=%b we=%b ack=%b addr=%h wd=%h rdat=%h, required cyc=%0d rd=%b we=%b ack=%b addr=%h dat=%h",
                                 e.nm, cyc, o_mem_rd, o_mem_we, o_host_ack, o_mem_addr, o_mem_wdata, ard,
                                 e.cyc, e.rd, e.we, e.ack, e.addr, e.dat);
                    end
                end
            end
            if (pix_q.size() > 0) begin
                p = pix_q.pop_front();
                n_cmp++;
                if (o_pixel !== p) begin
                    n_bad++;
                    $display("FAIL pixel x=%0d y=%0d en=%b: got %b, required %b",
                             i_pixel_x, i_pixel_y, i_enable, o_pixel, p);
                end
            end
        end
    end

    task automatic step(input bit en, input int x, input logic [7:0] y);
        @(posedge clk);
        #1;
        i_enable  = en;
        i_pixel_x = 9'(x);
        i_pixel_y = y;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 0, i_pixel_y);
            pix_q.push_back(1'b0);
        end
    endtask

    // One raster line x=0..xend then blanking.
    // hmode 1: host write requested at x=20 (in-line fetch decision cycle).
    // hmode 2: host write requested one cycle after the falling edge.
    task automatic run_line(input logic [7:0] y, input int xend, input int hmode);
        int          j;
        int          e;
        logic [7:0]  src;
        logic [7:0]  nl;
        logic [15:0] w;
        for (int x = 0; x <= xend; x++) begin
            step(1'b1, x, y);
            j   = x / 16;
            src = (j < 2) ? disp : y;
            w   = mem[{src, 5'(j)}];
            pix_q.push_back(w[15 - (x % 16)]);
            if ((x % 16) == PSLOT && j >= 1 && j <= 30)
                exp_rd($sformatf("inline_y%0d_w%0d", y, j + 1), cyc + 1, {y, 5'(j + 1)});
            if (hmode == 1 && x == 20) begin
                host_req  = 1'b1;
                host_addr = 13'h1F00;
                host_data = 16'hA5C3;
                exp_wr("host_vs_inline", cyc + 2, 13'h1F00, 16'hA5C3);
            end
            if (hmode == 1 && x == 23) host_req = 1'b0;
        end
        step(1'b0, 0, y);
        pix_q.push_back(1'b0);
        e  = cyc;
        nl = (y == 8'(LAST)) ? 8'd0 : y + 8'd1;
        exp_rd($sformatf("blank_l%0d_w0", nl), e + 2, {nl, 5'd0});
        exp_rd($sformatf("blank_l%0d_w1", nl), e + 3, {nl, 5'd1});
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 0, y);
            pix_q.push_back(1'b0);
            if (hmode == 2 && k == 1) begin
                host_req  = 1'b1;
                host_addr = 13'h1F01;
                host_data = 16'h5AA5;
                exp_wr("host_vs_blank", e + 4, 13'h1F01, 16'h5AA5);
            end
            if (hmode == 2 && k == 4) host_req = 1'b0;
        end
        disp = nl;
    endtask

    initial begin
        ev_t e;
        rst       = 1'b0;
        i_enable  = 1'b1;
        i_pixel_x = 9'd0;
        i_pixel_y = 8'd0;
        host_req  = 1'b0;
        host_addr = 13'd0;
        host_data = 16'd0;
`ifdef VIDEO_FB_HOST_READ_EN
        host_wr   = 1'b1;
`endif
        disp      = 8'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rd",    32'(o_mem_rd),    32'h0);
        chk("rst_mem_we",    32'(o_mem_we),    32'h0);
        chk("rst_host_ack",  32'(o_host_ack),  32'h0);
        chk("rst_mem_addr",  32'(o_mem_addr),  32'h0);
        chk("rst_mem_wdata", 32'(o_mem_wdata), 32'h0);
        chk("rst_pixel",     32'(o_pixel),     32'h0);

        @(posedge clk);
        #1;
        i_enable = 1'b0;
        rst      = 1'b1;
        exp_rd("reset_w0", cyc + 1, 13'd0);
        exp_rd("reset_w1", cyc + 2, 13'd1);
        idle(6);

        run_line(8'd0,   40,  0);
        run_line(8'd4,   3,   2);
        run_line(8'd5,   498, 1);
        run_line(8'd229, 3,   0);
        run_line(8'd0,   15,  0);

        // Host write with no video activity: acknowledged the next cycle.
        idle(1);
        host_req  = 1'b1;
        host_addr = 13'h1F02;
        host_data = 16'h0F0F;
        exp_wr("host_idle", cyc + 1, 13'h1F02, 16'h0F0F);
        idle(1);
        host_req = 1'b0;

`ifdef VIDEO_FB_HOST_READ_EN
        idle(1);
        host_req  = 1'b1;
        host_wr   = 1'b0;
        host_addr = 13'h123;
        exp_rd("host_rd_cmd", cyc + 1, 13'h123);
        exp_ack("host_rd_ack", cyc + 2, 16'hBEEF);
        idle(2);
        host_req = 1'b0;
        host_wr  = 1'b1;
`endif

        idle(6);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL ev_%s: got no access, required cyc=%0d addr=%h", e.nm, e.cyc, e.addr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
